vector_operand_collector: RTL and testbench

Multi-cycle operand fetch stage that sits directly upstream of the registered vector add unit. It accepts one issued vector instruction at a time and reads vs2, vs1 and v0 sequentially through a single synchronous VRF read port. It then presents the execution vector and the three VLEN-wide operands to the add unit with a valid/ready handshake. Scalar and immediate forms bypass the vs1 read; unmasked forms bypass the v0 read.

---
 rtl/vector_operand_collector.sv | 181 ++++++++++++++++++
 tb/tb_vector_operand_collector.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_operand_collector.sv
// Operand fetch stage that reads vs2, vs1 and v0 through one synchronous VRF port and
// hands them to the vector add unit. Optional v0 cache: VECTOR_OPERAND_COLLECTOR_V0_CACHE_EN.
package riscv_v_pkg;
    localparam int unsigned VLEN = 128;

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] sew;
        logic [4:0] vd;
        logic       vm;
    } execution_vector_t;
endpackage

module vector_operand_collector
    import riscv_v_pkg::*;
#(
    parameter int unsigned VREG_ADDR_W = 5
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  execution_vector_t      issue_execution_vector,
    input  logic [VREG_ADDR_W-1:0] issue_vs2_addr,
    input  logic [VREG_ADDR_W-1:0] issue_vs1_addr,
    input  logic                   issue_vs1_en,
    input  logic [VLEN-1:0]        issue_vs1_bypass,
    input  logic                   issue_vm,
    output logic                   vrf_read_enable,
    output logic [VREG_ADDR_W-1:0] vrf_read_addr,
    input  logic [VLEN-1:0]        vrf_read_data,
    input  logic                   v0_invalidate,
    output execution_vector_t      execution_vector,
    output logic [VLEN-1:0]        vs2,
    output logic [VLEN-1:0]        vs1,
    output logic [VLEN-1:0]        v0,
    output logic                   operands_valid,
    input  logic                   operands_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] TAG_VS2 = 2'd0;
    localparam logic [1:0] TAG_VS1 = 2'd1;
    localparam logic [1:0] TAG_V0  = 2'd2;

    state_t                   state_r;
    logic [VREG_ADDR_W-1:0]   vs1_addr_r;
    logic                     pend_vs1_r;
    logic                     pend_v0_r;
    logic [1:0]               rd_tag_r;
    logic                     cap_valid_r;
    logic [1:0]               cap_tag_r;
    logic                     accept_s;
    logic                     cache_hit_s;
    logic [VLEN-1:0]          v0_cache_s;

    assign accept_s = issue_valid && issue_ready;

`ifdef VECTOR_OPERAND_COLLECTOR_V0_CACHE_EN
    logic [VLEN-1:0] v0_cache_r;
    logic            v0_cache_valid_r;

    // An invalidate in the accept cycle forces a fresh VRF read of v0.
    assign cache_hit_s = v0_cache_valid_r && !v0_invalidate;
    assign v0_cache_s  = v0_cache_r;

    // v0 cache fill on every v0 capture; a coincident invalidate leaves it invalid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v0_cache_r       <= '0;
            v0_cache_valid_r <= 1'b0;
        end else if (cap_valid_r && (cap_tag_r == TAG_V0)) begin
            v0_cache_r       <= vrf_read_data;
            v0_cache_valid_r <= !v0_invalidate;
        end else if (v0_invalidate) begin
            v0_cache_valid_r <= 1'b0;
        end
    end
`else
    logic unused_v0_invalidate_s;

    assign cache_hit_s            = 1'b0;
    assign v0_cache_s             = '0;
    assign unused_v0_invalidate_s = v0_invalidate;
`endif

    // Fetch sequencer, read-data capture pipeline and registered handshake outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= IDLE;
            issue_ready      <= 1'b1;
            operands_valid   <= 1'b0;
            vrf_read_enable  <= 1'b0;
            vrf_read_addr    <= '0;
            execution_vector <= '0;
            vs2              <= '0;
            vs1              <= '0;
            v0               <= '0;
            vs1_addr_r       <= '0;
            pend_vs1_r       <= 1'b0;
            pend_v0_r        <= 1'b0;
            rd_tag_r         <= TAG_VS2;
            cap_valid_r      <= 1'b0;
            cap_tag_r        <= TAG_VS2;
        end else begin
            // Read data arrives one cycle after the strobe, so the tag trails by one stage.
            cap_valid_r <= vrf_read_enable;
            cap_tag_r   <= rd_tag_r;
            if (cap_valid_r) begin
                case (cap_tag_r)
                    TAG_VS2: vs2 <= vrf_read_data;
                    TAG_VS1: vs1 <= vrf_read_data;
                    TAG_V0:  v0  <= vrf_read_data;
                    default: ;
                endcase
            end

            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        execution_vector <= issue_execution_vector;
                        vs1_addr_r       <= issue_vs1_addr;
                        pend_vs1_r       <= issue_vs1_en;
                        pend_v0_r        <= !issue_vm && !cache_hit_s;
                        if (!issue_vs1_en) begin
                            vs1 <= issue_vs1_bypass;
                        end
                        if (issue_vm) begin
                            v0 <= '1;
                        end else if (cache_hit_s) begin
                            v0 <= v0_cache_s;
                        end
                        vrf_read_enable <= 1'b1;
                        vrf_read_addr   <= issue_vs2_addr;
                        rd_tag_r        <= TAG_VS2;
                        issue_ready     <= 1'b0;
                        state_r         <= FETCH;
                    end
                end
                FETCH: begin
                    if (pend_vs1_r) begin
                        vrf_read_addr <= vs1_addr_r;
                        rd_tag_r      <= TAG_VS1;
                        pend_vs1_r    <= 1'b0;
                    end else if (pend_v0_r) begin
                        vrf_read_addr <= '0;
                        rd_tag_r      <= TAG_V0;
                        pend_v0_r     <= 1'b0;
                    end else begin
                        vrf_read_enable <= 1'b0;
                        state_r         <= DRAIN;
                    end
                end
                DRAIN: begin
                    operands_valid <= 1'b1;
                    state_r        <= HOLD;
                end
                HOLD: begin
                    if (operands_ready) begin
                        operands_valid <= 1'b0;
                        issue_ready    <= 1'b1;
                        state_r        <= IDLE;
                    end
                end
                default: begin
                    operands_valid  <= 1'b0;
                    vrf_read_enable <= 1'b0;
                    issue_ready     <= 1'b1;
                    state_r         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_operand_collector.sv
// Randomized self-checking bench for vector_operand_collector against a read-list/latency model.
module tb_vector_operand_collector;
    import riscv_v_pkg::*;

    localparam int AW  = 5;
    localparam int EVW = $bits(execution_vector_t);
`ifdef VECTOR_OPERAND_COLLECTOR_V0_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset_n;
    logic              issue_valid;
    logic              issue_ready;
    execution_vector_t issue_execution_vector;
    logic [AW-1:0]     issue_vs2_addr, issue_vs1_addr;
    logic              issue_vs1_en;
    logic [VLEN-1:0]   issue_vs1_bypass;
    logic              issue_vm;
    logic              vrf_read_enable;
    logic [AW-1:0]     vrf_read_addr;
    logic [VLEN-1:0]   vrf_read_data;
    logic              v0_invalidate;
    execution_vector_t execution_vector;
    logic [VLEN-1:0]   vs2, vs1, v0;
    logic              operands_valid;
    logic              operands_ready;

    vector_operand_collector #(.VREG_ADDR_W(AW)) dut (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_execution_vector(issue_execution_vector),
        .issue_vs2_addr(issue_vs2_addr), .issue_vs1_addr(issue_vs1_addr),
        .issue_vs1_en(issue_vs1_en), .issue_vs1_bypass(issue_vs1_bypass),
        .issue_vm(issue_vm),
        .vrf_read_enable(vrf_read_enable), .vrf_read_addr(vrf_read_addr),
        .vrf_read_data(vrf_read_data), .v0_invalidate(v0_invalidate),
        .execution_vector(execution_vector), .vs2(vs2), .vs1(vs1), .v0(v0),
        .operands_valid(operands_valid), .operands_ready(operands_ready)
    );

    always #5 clock = ~clock;

    // Synchronous VRF model: data one cycle after the strobe.
    logic [VLEN-1:0] vrf_mem [32];
    always @(posedge clock) begin
        if (vrf_read_enable) vrf_read_data <= vrf_mem[vrf_read_addr];
    end

    int total = 0;
    int bad   = 0;

    // Reference model state and per-op observations.
    bit                model_cache_valid;
    int                exp_reads[$];
    int                obs_reads[$];
    int                obs_lat, obs_wait, stable_bad, ir_bad;
    logic              post_valid, post_ready;
    logic [VLEN-1:0]   obs_vs2, obs_vs1, obs_v0;
    execution_vector_t obs_ev;

    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] r;
        for (int i = 0; i < VLEN / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Expected read list: vs2, optional vs1, optional v0 (skipped on a model cache hit).
    function automatic void model_expect(input logic [AW-1:0] a2, input logic [AW-1:0] a1,
                                         input logic en, input logic vm);
        exp_reads.delete();
        exp_reads.push_back(int'(a2));
        if (en) exp_reads.push_back(int'(a1));
        if (!vm && !(CACHE_EN && model_cache_valid)) exp_reads.push_back(0);
        if (!vm) model_cache_valid = CACHE_EN;
    endfunction

    task automatic pulse_invalidate();
        v0_invalidate = 1'b1;
        vrf_mem[0] = rand_vec();
        @(negedge clock);
        v0_invalidate = 1'b0;
        model_cache_valid = 1'b0;
    endtask

    // Issue one instruction (called at a negedge), observe fetch, hold, then handshake.
    task automatic run_op(input execution_vector_t ev, input logic [AW-1:0] a2,
                          input logic [AW-1:0] a1, input logic en,
                          input logic [VLEN-1:0] byp, input logic vm, input int hold);
        obs_reads.delete();
        obs_lat = -1; obs_wait = 0; stable_bad = 0; ir_bad = 0;
        post_valid = 1'bx; post_ready = 1'bx;
        while (!issue_ready && obs_wait < 20) begin
            @(negedge clock);
            obs_wait++;
        end
        issue_execution_vector = ev; issue_vs2_addr = a2; issue_vs1_addr = a1;
        issue_vs1_en = en; issue_vs1_bypass = byp; issue_vm = vm; issue_valid = 1'b1;
        @(posedge clock);
        #1 issue_valid = 1'b0;
        issue_vs1_bypass = rand_vec();
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (vrf_read_enable) obs_reads.push_back(int'(vrf_read_addr));
            if (operands_valid) begin
                obs_lat = c - 1;
                break;
            end
        end
        if (obs_lat < 0) return;
        obs_vs2 = vs2; obs_vs1 = vs1; obs_v0 = v0; obs_ev = execution_vector;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            if (vs2 !== obs_vs2 || vs1 !== obs_vs1 || v0 !== obs_v0 || execution_vector !== obs_ev
                || operands_valid !== 1'b1) stable_bad++;
            if (issue_ready !== 1'b0) ir_bad++;
        end
        operands_ready = 1'b1;
        @(posedge clock);
        #1 operands_ready = 1'b0;
        @(negedge clock);
        post_valid = operands_valid;
        post_ready = issue_ready;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'($urandom); issue_vm = 1'($urandom); issue_vs1_en = 1'($urandom);
            issue_vs2_addr = 5'($urandom); operands_ready = 1'($urandom);
            v0_invalidate = 1'($urandom); issue_vs1_bypass = rand_vec();
            @(negedge clock);
            total++;
            if (issue_ready !== 1'b1 || operands_valid !== 1'b0 || vrf_read_enable !== 1'b0) begin
                bad++;
                $display("FAIL reset_ctrl: got ready=%b valid=%b ren=%b want 1 0 0",
                         issue_ready, operands_valid, vrf_read_enable);
            end
            total++;
            if (vs2 !== '0 || vs1 !== '0 || v0 !== '0 || execution_vector !== '0 || vrf_read_addr !== '0) begin
                bad++;
                $display("FAIL reset_data: got vs2=%h vs1=%h v0=%h ev=%h addr=%0d want all 0",
                         vs2, vs1, v0, execution_vector, vrf_read_addr);
            end
        end
        issue_valid = 1'b0; operands_ready = 1'b0; v0_invalidate = 1'b0;
        reset_n = 1'b1;
        model_cache_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_vs_unmasked();
        logic [VLEN-1:0] byp;
        byp = {(VLEN/8){8'h05}};
        model_expect(5'd3, 5'd0, 1'b0, 1'b1);
        run_op(execution_vector_t'(EVW'($urandom)), 5'd3, 5'd9, 1'b0, byp, 1'b1, 0);
        total++;
        if (obs_lat !== 2 || obs_reads.size() != 1) begin
            bad++;
            $display("FAIL vs_lat: got lat=%0d reads=%0d want lat=2 reads=1", obs_lat, obs_reads.size());
        end else begin
            total++;
            if (obs_reads[0] != 3) begin
                bad++;
                $display("FAIL vs_addr: got %0d want 3", obs_reads[0]);
            end
        end
        total++;
        if (obs_vs2 !== vrf_mem[3] || obs_vs1 !== byp || obs_v0 !== {VLEN{1'b1}}) begin
            bad++;
            $display("FAIL vs_data: got vs2=%h vs1=%h v0=%h want %h %h all-ones",
                     obs_vs2, obs_vs1, obs_v0, vrf_mem[3], byp);
        end
    endtask

    task automatic test_masked_vv();
        execution_vector_t ev;
        ev = execution_vector_t'(EVW'($urandom));
        model_expect(5'd4, 5'd7, 1'b1, 1'b0);
        run_op(ev, 5'd4, 5'd7, 1'b1, rand_vec(), 1'b0, 0);
        total++;
        if (obs_lat !== 4 || obs_reads.size() != 3) begin
            bad++;
            $display("FAIL vv_lat: got lat=%0d reads=%0d want lat=4 reads=3", obs_lat, obs_reads.size());
        end else begin
            total++;
            if (obs_reads[0] != 4 || obs_reads[1] != 7 || obs_reads[2] != 0) begin
                bad++;
                $display("FAIL vv_addr: got %0d,%0d,%0d want 4,7,0", obs_reads[0], obs_reads[1], obs_reads[2]);
            end
        end
        total++;
        if (obs_vs2 !== vrf_mem[4] || obs_vs1 !== vrf_mem[7] || obs_v0 !== vrf_mem[0] || obs_ev !== ev) begin
            bad++;
            $display("FAIL vv_data: got vs2=%h vs1=%h v0=%h ev=%h want %h %h %h %h",
                     obs_vs2, obs_vs1, obs_v0, obs_ev, vrf_mem[4], vrf_mem[7], vrf_mem[0], ev);
        end
    endtask

    task automatic test_backpressure();
        model_expect(5'd10, 5'd11, 1'b1, 1'b1);
        run_op(execution_vector_t'(EVW'($urandom)), 5'd10, 5'd11, 1'b1, rand_vec(), 1'b1, 5);
        total++;
        if (stable_bad != 0 || ir_bad != 0) begin
            bad++;
            $display("FAIL bp_hold: got unstable=%0d ready_high=%0d want 0 0", stable_bad, ir_bad);
        end
        total++;
        if (post_valid !== 1'b0 || post_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got valid=%b ready=%b want 0 1", post_valid, post_ready);
        end
        model_expect(5'd12, 5'd0, 1'b0, 1'b1);
        run_op(execution_vector_t'(EVW'($urandom)), 5'd12, 5'd0, 1'b0, rand_vec(), 1'b1, 0);
        total++;
        if (obs_wait != 0 || obs_lat !== 2 || obs_vs2 !== vrf_mem[12]) begin
            bad++;
            $display("FAIL bp_next: got wait=%0d lat=%0d vs2=%h want 0 2 %h", obs_wait, obs_lat, obs_vs2, vrf_mem[12]);
        end
    endtask

    task automatic test_reset_midop();
        int seen_valid;
        seen_valid = 0;
        issue_execution_vector = execution_vector_t'(EVW'($urandom));
        issue_vs2_addr = 5'd20; issue_vs1_addr = 5'd21; issue_vs1_en = 1'b1; issue_vm = 1'b0;
        issue_valid = 1'b1;
        @(posedge clock);
        #1 issue_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        total++;
        if (vrf_read_enable !== 1'b1 || vrf_read_addr !== 5'd21) begin
            bad++;
            $display("FAIL mid_second_read: got ren=%b addr=%0d want 1 21", vrf_read_enable, vrf_read_addr);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (issue_ready !== 1'b1 || operands_valid !== 1'b0 || vrf_read_enable !== 1'b0 || vs2 !== '0) begin
            bad++;
            $display("FAIL mid_abort: got ready=%b valid=%b ren=%b vs2=%h want 1 0 0 0",
                     issue_ready, operands_valid, vrf_read_enable, vs2);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (operands_valid !== 1'b0) seen_valid++;
        end
        reset_n = 1'b1;
        model_cache_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (operands_valid !== 1'b0) seen_valid++;
        end
        total++;
        if (seen_valid != 0) begin
            bad++;
            $display("FAIL mid_no_valid: got %0d valid cycles want 0", seen_valid);
        end
        model_expect(5'd22, 5'd23, 1'b1, 1'b0);
        run_op(execution_vector_t'(EVW'($urandom)), 5'd22, 5'd23, 1'b1, rand_vec(), 1'b0, 1);
        total++;
        if (obs_lat !== 4 || obs_vs2 !== vrf_mem[22] || obs_vs1 !== vrf_mem[23] || obs_v0 !== vrf_mem[0]) begin
            bad++;
            $display("FAIL mid_after: got lat=%0d vs2=%h vs1=%h v0=%h want 4 %h %h %h",
                     obs_lat, obs_vs2, obs_vs1, obs_v0, vrf_mem[22], vrf_mem[23], vrf_mem[0]);
        end
    endtask

`ifdef VECTOR_OPERAND_COLLECTOR_V0_CACHE_EN
    task automatic test_v0_cache();
        int n[3];
        int last_addr;
        pulse_invalidate();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) pulse_invalidate();
            model_expect(5'(k + 1), 5'(k + 5), 1'b1, 1'b0);
            run_op(execution_vector_t'(EVW'($urandom)), 5'(k + 1), 5'(k + 5), 1'b1, rand_vec(), 1'b0, 0);
            n[k] = obs_reads.size();
            last_addr = (n[k] > 0) ? obs_reads[n[k]-1] : -1;
            total++;
            if (obs_v0 !== vrf_mem[0]) begin
                bad++;
                $display("FAIL cache_v0_%0d: got %h want %h", k, obs_v0, vrf_mem[0]);
            end
        end
        total++;
        if (n[0] != 3 || n[1] != 2 || n[2] != 3 || last_addr != 0) begin
            bad++;
            $display("FAIL cache_reads: got %0d,%0d,%0d last=%0d want 3,2,3 last=0", n[0], n[1], n[2], last_addr);
        end
    endtask
`endif

    task automatic test_random();
        execution_vector_t ev;
        logic [AW-1:0]     a2, a1;
        logic              en, vm;
        logic [VLEN-1:0]   byp;
        int                hold;
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 3) == 0) pulse_invalidate();
            vrf_mem[$urandom_range(1, 31)] = rand_vec();
            ev = execution_vector_t'(EVW'($urandom));
            a2 = 5'($urandom); a1 = 5'($urandom);
            en = 1'($urandom); vm = 1'($urandom);
            byp = rand_vec(); hold = $urandom_range(0, 3);
            model_expect(a2, a1, en, vm);
            run_op(ev, a2, a1, en, byp, vm, hold);
            total++;
            if (obs_lat !== exp_reads.size() + 1 || obs_reads != exp_reads) begin
                bad++;
                $display("FAIL rnd_seq[%0d]: got lat=%0d reads=%p want lat=%0d reads=%p",
                         t, obs_lat, obs_reads, exp_reads.size() + 1, exp_reads);
            end
            total++;
            if (obs_vs2 !== vrf_mem[a2] || obs_vs1 !== (en ? vrf_mem[a1] : byp)
                || obs_v0 !== (vm ? {VLEN{1'b1}} : vrf_mem[0]) || obs_ev !== ev) begin
                bad++;
                $display("FAIL rnd_data[%0d]: got vs2=%h vs1=%h v0=%h ev=%h", t, obs_vs2, obs_vs1, obs_v0, obs_ev);
            end
            total++;
            if (stable_bad != 0 || ir_bad != 0 || post_valid !== 1'b0 || post_ready !== 1'b1) begin
                bad++;
                $display("FAIL rnd_hs[%0d]: got unstable=%0d ready_high=%0d post_valid=%b post_ready=%b want 0 0 0 1",
                         t, stable_bad, ir_bad, post_valid, post_ready);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) vrf_mem[i] = rand_vec();
        issue_valid = 1'b0; operands_ready = 1'b0; v0_invalidate = 1'b0;
        issue_execution_vector = '0; issue_vs2_addr = '0; issue_vs1_addr = '0;
        issue_vs1_en = 1'b0; issue_vs1_bypass = '0; issue_vm = 1'b1;
        model_cache_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        test_reset();
        test_vs_unmasked();
        test_masked_vv();
        test_backpressure();
        test_reset_midop();
`ifdef VECTOR_OPERAND_COLLECTOR_V0_CACHE_EN
        test_v0_cache();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
